// File: rtl/serial_slave_port.sv
// rtl/serial_slave_port.sv - bit-serial bus slave issuing read/write strobes to a local synchronous RAM
module serial_slave_port #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_en,
    input  logic                write_en,
    input  logic                master_valid,
    input  logic                master_ready,
    input  logic                rx_address,
    input  logic                rx_burst,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic                slave_valid,
    output logic                tx_data,
    output logic                busy,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    localparam int CNT_MAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_LEN - 1);
    localparam logic [CNT_W-1:0]     DATA_LAST = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0]     BURST_CAP = CNT_W'(BURST_LEN);
    localparam logic [BURST_LEN-1:0] BEAT_ONE  = BURST_LEN'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRITE,
        S_RREQ,
        S_RWAIT,
        S_RDATA
    } state_t;

    state_t               state_q, state_d;
    logic                 is_read_q, is_read_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BURST_LEN-1:0] burst_q, burst_d;
    logic [BURST_LEN-1:0] beat_q, beat_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [DATA_LEN-1:0]  wdata_q, wdata_d;
    logic [DATA_LEN-1:0]  tx_q, tx_d;
    logic                 cmd_live;

    // Master keeps at least one of the enables high for the whole transaction; dropping both aborts.
    assign cmd_live = read_en | write_en;

    // Next-state and datapath decode; serial fields arrive LSB first so they shift in from the top.
    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        bit_cnt_d = bit_cnt_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        case (state_q)
            S_IDLE: begin
                if (master_valid && (read_en ^ write_en)) begin
                    is_read_d = read_en;
                    addr_d    = {rx_address, addr_q[ADDR_LEN-1:1]};
                    burst_d   = {rx_burst, burst_q[BURST_LEN-1:1]};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!cmd_live) begin
                    state_d = S_IDLE;
                end else if (master_valid) begin
                    addr_d = {rx_address, addr_q[ADDR_LEN-1:1]};
                    if (bit_cnt_q < BURST_CAP) begin
                        burst_d = {rx_burst, burst_q[BURST_LEN-1:1]};
                    end
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        beat_d    = (burst_d == '0) ? BEAT_ONE : burst_d;
                        state_d   = is_read_q ? S_RREQ : S_WDATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (!cmd_live) begin
                    state_d = S_IDLE;
                end else if (master_valid) begin
                    wdata_d = {rx_data, wdata_q[DATA_LEN-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_WRITE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                beat_d  = beat_q - 1'b1;
                state_d = (beat_q == BEAT_ONE) ? S_IDLE : S_WDATA;
            end
            S_RREQ: begin
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                tx_d    = mem_rdata;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                if (!cmd_live) begin
                    state_d = S_IDLE;
                end else if (master_ready) begin
                    tx_d = {1'b0, tx_q[DATA_LEN-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_q + 1'b1;
                        beat_d    = beat_q - 1'b1;
                        state_d   = (beat_q == BEAT_ONE) ? S_IDLE : S_RREQ;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including a burst in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            is_read_q <= 1'b0;
            bit_cnt_q <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            bit_cnt_q <= bit_cnt_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
        end
    end

    assign slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign slave_valid = (state_q == S_RDATA);
    assign tx_data     = slave_valid & tx_q[0];
    assign busy        = (state_q != S_IDLE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = (state_q == S_WRITE);
    assign mem_re      = (state_q == S_RREQ);

endmodule

// File: tb/tb_serial_slave_port.sv
// tb/tb_serial_slave_port.sv - randomized self-checking bench for serial_slave_port
`timescale 1ns/1ps
module tb_serial_slave_port;

    localparam int AL = 12;
    localparam int DL = 8;

    logic          clk = 1'b0;
    logic          rst, read_en, write_en, master_valid, master_ready;
    logic          rx_address, rx_burst, rx_data;
    logic          slave_ready, slave_valid, tx_data, busy, mem_we, mem_re;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    serial_slave_port #(.ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(12)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .master_valid(master_valid), .master_ready(master_ready),
        .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // RAM seen by the DUT, and the bench's own idea of what it should contain
    logic [DL-1:0] ram     [0:4095];
    logic [DL-1:0] ref_mem [0:4095];

    always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

    int            tests = 0;
    int            fails = 0;
    logic [7:0]    wr_bytes[$];
    int            we_t[$];
    logic [11:0]   we_a[$];
    logic [7:0]    we_d[$];
    int            re_t[$];
    logic          rx_bits[$];
    int            first_sv;
    int            end_cycle;
    logic          end_sv, end_ready;
    logic [11:0]   end_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction bit by bit; t=0 is the start cycle. Logs strobes and received bits.
    task automatic run_txn(input bit is_rd, input logic [11:0] a, input logic [11:0] b,
                           input int stall_pct, input int nrdy_pct,
                           input int stall_from, input int stall_n,
                           input int nrdy_from, input int nrdy_n,
                           input int abort_at, input int rst_at);
        logic [2:0] bits[$];
        logic [7:0] byte_v;
        int t;
        bit started, done, mv, mr;
        bits = {};
        for (int i = 0; i < AL; i++) bits.push_back({a[i], b[i], 1'b0});
        if (!is_rd) begin
            foreach (wr_bytes[k]) begin
                byte_v = wr_bytes[k];
                for (int j = 0; j < DL; j++) bits.push_back({2'b00, byte_v[j]});
            end
        end
        we_t.delete(); we_a.delete(); we_d.delete(); re_t.delete(); rx_bits.delete();
        first_sv = -1;
        end_cycle = -1;
        read_en = is_rd;
        write_en = !is_rd;
        t = 0;
        started = 0;
        done = 0;
        while (!done && t < 2000) begin
            if (started && !busy) begin
                done = 1;
                end_cycle = t;
                end_sv = slave_valid;
                end_ready = slave_ready;
                end_addr = mem_addr;
            end else begin
                if (mem_we) begin
                    we_t.push_back(t); we_a.push_back(mem_addr); we_d.push_back(mem_wdata);
                    ram[mem_addr] = mem_wdata;
                end
                if (mem_re) re_t.push_back(t);
                if (slave_valid && first_sv < 0) first_sv = t;
                rst = (t == rst_at) ? 1'b0 : 1'b1;
                if (abort_at >= 0 && t >= abort_at) begin
                    read_en = 1'b0;
                    write_en = 1'b0;
                end
                mv = (bits.size() > 0) && (t == 0 || $urandom_range(99) >= stall_pct)
                     && !(t >= stall_from && t < stall_from + stall_n);
                mr = ($urandom_range(99) >= nrdy_pct) && !(t >= nrdy_from && t < nrdy_from + nrdy_n);
                master_valid = mv;
                master_ready = mr;
                if (mv) {rx_address, rx_burst, rx_data} = bits[0];
                if (mv && slave_ready) begin
                    void'(bits.pop_front());
                    if (!busy) started = 1;
                end
                if (slave_valid && mr) rx_bits.push_back(tx_data);
                tick();
                t++;
            end
        end
        master_valid = 1'b0; master_ready = 1'b0; read_en = 1'b0; write_en = 1'b0; rst = 1'b1;
        if (!done) begin
            tests++; fails++;
            $display("FAIL txn_timeout: busy=%0b after %0d cycles, want return to idle", busy, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        tests += 8;
        if (slave_ready !== 1'b1) begin fails++; $display("FAIL reset_slave_ready: got %0b want 1", slave_ready); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (slave_valid !== 1'b0) begin fails++; $display("FAIL reset_slave_valid: got %0b want 0", slave_valid); end
        if (tx_data !== 1'b0) begin fails++; $display("FAIL reset_tx_data: got %0b want 0", tx_data); end
        if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        if (mem_re !== 1'b0) begin fails++; $display("FAIL reset_mem_re: got %0b want 0", mem_re); end
        if (mem_addr !== 12'h000) begin fails++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
        if (mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        wr_bytes = '{8'h3C};
        run_txn(1'b0, 12'h0A5, 12'd1, 0, 0, -1, 0, -1, 0, -1, -1);
        tests++;
        if (we_t.size() != 1) begin fails++; $display("FAIL sw_count: got %0d strobes want 1", we_t.size()); end
        else begin
            tests += 3;
            if (we_t[0] != 20) begin fails++; $display("FAIL sw_time: got t%0d want t20", we_t[0]); end
            if (we_a[0] !== 12'h0A5) begin fails++; $display("FAIL sw_addr: got %h want 0a5", we_a[0]); end
            if (we_d[0] !== 8'h3C) begin fails++; $display("FAIL sw_data: got %h want 3c", we_d[0]); end
        end
        tests++;
        if (end_cycle != 21) begin fails++; $display("FAIL sw_idle: got t%0d want t21", end_cycle); end
    endtask

    task automatic test_single_read();
        logic [7:0] exp_b;
        exp_b = 8'h3C;
        ram[12'h0A5] = exp_b;
        run_txn(1'b1, 12'h0A5, 12'd1, 0, 0, -1, 0, -1, 0, -1, -1);
        tests += 4;
        if (re_t.size() != 1 || re_t[0] != 12) begin fails++; $display("FAIL sr_mem_re: got %0d strobes first t%0d want 1 at t12", re_t.size(), (re_t.size() > 0) ? re_t[0] : -1); end
        if (first_sv != 14) begin fails++; $display("FAIL sr_valid_start: got t%0d want t14", first_sv); end
        if (end_cycle != 22) begin fails++; $display("FAIL sr_idle: got t%0d want t22", end_cycle); end
        if (end_sv !== 1'b0) begin fails++; $display("FAIL sr_valid_drop: got %0b want 0", end_sv); end
        tests++;
        if (rx_bits.size() != 8) begin fails++; $display("FAIL sr_bitcount: got %0d want 8", rx_bits.size()); end
        else for (int j = 0; j < 8; j++) begin
            tests++;
            if (rx_bits[j] !== exp_b[j]) begin fails++; $display("FAIL sr_bit%0d: got %0b want %0b", j, rx_bits[j], exp_b[j]); end
        end
    endtask

    task automatic test_write_burst();
        logic [11:0] ea;
        wr_bytes = '{8'h11, 8'h22, 8'h33};
        run_txn(1'b0, 12'hFFE, 12'd3, 0, 0, -1, 0, -1, 0, -1, -1);
        tests++;
        if (we_t.size() != 3) begin fails++; $display("FAIL wb_count: got %0d want 3", we_t.size()); end
        else for (int i = 0; i < 3; i++) begin
            ea = 12'hFFE + 12'(i);
            tests += 3;
            if (we_t[i] != 20 + 9 * i) begin fails++; $display("FAIL wb_time%0d: got t%0d want t%0d", i, we_t[i], 20 + 9 * i); end
            if (we_a[i] !== ea) begin fails++; $display("FAIL wb_addr%0d: got %h want %h", i, we_a[i], ea); end
            if (we_d[i] !== wr_bytes[i]) begin fails++; $display("FAIL wb_data%0d: got %h want %h", i, we_d[i], wr_bytes[i]); end
        end
        tests++;
        if (end_cycle != 39) begin fails++; $display("FAIL wb_idle: got t%0d want t39", end_cycle); end
    endtask

    task automatic test_stalls();
        logic [7:0] got;
        ram[12'h0A5] = 8'h3C;
        run_txn(1'b1, 12'h0A5, 12'd1, 0, 0, 5, 3, 20, 2, -1, -1);
        tests += 2;
        if (end_cycle != 27) begin fails++; $display("FAIL st_idle: got t%0d want t27", end_cycle); end
        if (re_t.size() != 1 || re_t[0] != 15) begin fails++; $display("FAIL st_mem_re: got %0d strobes want 1 at t15", re_t.size()); end
        tests++;
        if (rx_bits.size() != 8) begin fails++; $display("FAIL st_bitcount: got %0d want 8", rx_bits.size()); end
        else begin
            for (int j = 0; j < 8; j++) got[j] = rx_bits[j];
            tests++;
            if (got !== 8'h3C) begin fails++; $display("FAIL st_data: got %h want 3c", got); end
        end
    endtask

    task automatic test_illegal_and_abort();
        read_en = 1'b1; write_en = 1'b1; master_valid = 1'b1; rx_address = 1'b1; rx_burst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (busy !== 1'b0) begin fails++; $display("FAIL both_en_busy: cycle %0d got %0b want 0", i, busy); end
        end
        master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;
        wr_bytes = '{8'hA7};
        run_txn(1'b0, 12'h055, 12'd1, 0, 0, -1, 0, -1, 0, 15, -1);
        tests += 2;
        if (we_t.size() != 0) begin fails++; $display("FAIL abort_we: got %0d strobes want 0", we_t.size()); end
        if (end_cycle != 16) begin fails++; $display("FAIL abort_idle: got t%0d want t16", end_cycle); end
    endtask

    task automatic test_reset_mid_read();
        run_txn(1'b1, 12'h200, 12'd4, 0, 0, -1, 0, -1, 0, -1, 27);
        tests += 4;
        if (end_cycle != 28) begin fails++; $display("FAIL rmr_idle: got t%0d want t28", end_cycle); end
        if (end_sv !== 1'b0) begin fails++; $display("FAIL rmr_valid: got %0b want 0", end_sv); end
        if (end_addr !== 12'h000) begin fails++; $display("FAIL rmr_addr: got %h want 000", end_addr); end
        if (end_ready !== 1'b1) begin fails++; $display("FAIL rmr_ready: got %0b want 1", end_ready); end
        wr_bytes = '{8'h5A};
        run_txn(1'b0, 12'h123, 12'd1, 0, 0, -1, 0, -1, 0, -1, -1);
        tests++;
        if (we_t.size() != 1 || we_t[0] != 20 || we_a[0] !== 12'h123 || we_d[0] !== 8'h5A)
        begin fails++; $display("FAIL rmr_write: got %0d strobes want one at t20 to 123 with 5a", we_t.size()); end
    endtask

    // Random back-to-back reads/writes against a reference memory
    task automatic test_back_to_back();
        bit is_rd, quiet;
        logic [11:0] a, b, ea;
        logic [7:0] got;
        int beats, sp, rp, exp_end;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        for (int n = 0; n < 30; n++) begin
            is_rd = 1'($urandom_range(1));
            a = 12'($urandom);
            if (n < 2) a = 12'hFFF;
            b = 12'($urandom_range(4));
            beats = (b == 0) ? 1 : int'(b);
            quiet = 1'($urandom_range(1));
            sp = quiet ? 0 : $urandom_range(30);
            rp = quiet ? 0 : $urandom_range(30);
            wr_bytes = {};
            if (!is_rd) for (int k = 0; k < beats; k++) wr_bytes.push_back(8'($urandom));
            run_txn(is_rd, a, b, sp, rp, -1, 0, -1, 0, -1, -1);
            if (is_rd) begin
                tests++;
                if (rx_bits.size() != beats * 8) begin fails++; $display("FAIL rnd%0d_rd_bits: got %0d want %0d", n, rx_bits.size(), beats * 8); end
                else for (int k = 0; k < beats; k++) begin
                    ea = a + 12'(k);
                    for (int j = 0; j < 8; j++) got[j] = rx_bits[k * 8 + j];
                    tests++;
                    if (got !== ref_mem[ea]) begin fails++; $display("FAIL rnd%0d_rd_beat%0d: got %h want %h at %h", n, k, got, ref_mem[ea], ea); end
                end
            end else begin
                tests++;
                if (we_t.size() != beats) begin fails++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", n, we_t.size(), beats); end
                else for (int k = 0; k < beats; k++) begin
                    ea = a + 12'(k);
                    tests++;
                    if (we_a[k] !== ea || we_d[k] !== wr_bytes[k]) begin fails++; $display("FAIL rnd%0d_wr_beat%0d: got %h@%h want %h@%h", n, k, we_d[k], we_a[k], wr_bytes[k], ea); end
                end
                for (int k = 0; k < beats; k++) ref_mem[a + 12'(k)] = wr_bytes[k];
            end
            if (quiet) begin
                exp_end = 12 + beats * (is_rd ? 10 : 9);
                tests++;
                if (end_cycle != exp_end) begin fails++; $display("FAIL rnd%0d_latency: got t%0d want t%0d", n, end_cycle, exp_end); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
        rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        test_reset();
        test_single_write();
        test_single_read();
        test_write_burst();
        test_stalls();
        test_illegal_and_abort();
        test_reset_mid_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
